// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative unsigned shift-add multiplier, one bit per clock.
// Optional SEQ_MUL_EARLY_EXIT_EN finishes once the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int unsigned l = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [l-1:0] ProductLow,
  output logic [l-1:0] ProductHigh
);

  localparam int unsigned CW = $clog2(l + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [l-1:0]    mcand;
  logic [2*l-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [l:0]      sum;
  logic [2*l-1:0]  shifted;
  logic [2*l-1:0]  result;
  logic            finish;
  logic            accept;

  // one shift-add step: add multiplicand to upper half, shift the whole register right
  always_comb begin
    sum     = {1'b0, acc[2*l-1:l]} + (acc[0] ? {1'b0, mcand} : '0);
    shifted = {sum, acc[l-1:1]};
    cnt_nx  = cnt + 1'b1;
  end

`ifdef SEQ_MUL_EARLY_EXIT_EN
  logic [l-1:0] mask;

  // low bits still holding unprocessed multiplier; stop once they are all zero
  always_comb begin
    mask   = {l{1'b1}} >> cnt_nx;
    finish = (shifted[l-1:0] & mask) == '0;
    result = shifted >> (CW'(l) - cnt_nx);
  end
`else
  // fixed latency: finish after all l multiplier bits
  always_comb begin
    finish = cnt_nx == CW'(l);
    result = shifted;
  end
`endif

  assign accept = Start && (state == IDLE || state == DONE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state and handshake outputs
  always_comb begin
    state_nx = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) state_nx = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (finish) state_nx = DONE;
      end
      DONE: begin
        Done     = 1'b1;
        state_nx = Start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand       <= '0;
      acc         <= '0;
      cnt         <= '0;
      ProductLow  <= '0;
      ProductHigh <= '0;
    end else if (accept) begin
      mcand <= A;
      acc   <= {{l{1'b0}}, B};
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= shifted;
      cnt <= cnt_nx;
      if (finish) begin
        ProductHigh <= result[2*l-1:l];
        ProductLow  <= result[l-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of the sequential multiplier.
// Latency expectations follow SEQ_MUL_EARLY_EXIT_EN when it is defined.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Busy;
  logic        Done;
  logic [15:0] ProductLow;
  logic [15:0] ProductHigh;

  int n_tests = 0;
  int n_fail  = 0;

  seq_multiplier #(.l(16)) dut (
    .clk(clk),
    .rst(rst),
    .Start(Start),
    .A(A),
    .B(B),
    .Busy(Busy),
    .Done(Done),
    .ProductLow(ProductLow),
    .ProductHigh(ProductHigh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    int p;
    p = -1;
    for (int i = 0; i < 16; i++)
      if (b[i]) p = i;
    return (p + 1 < 1) ? 1 : p + 1;
`else
    return (b === 16'hxxxx) ? 0 : 16;
`endif
  endfunction

  function automatic logic [31:0] prod();
    return {ProductHigh, ProductLow};
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    Start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat,
                           input logic [31:0] exp,
                           input logic [31:0] prev);
    int k;
    bit bad_busy;
    bit bad_hold;
    k = 0;
    bad_busy = 0;
    bad_hold = 0;
    while (k < 64) begin
      @(posedge clk);
      #1;
      k++;
      if (Done) break;
      if (!Busy) bad_busy = 1;
      if (prod() !== prev) bad_hold = 1;
    end
    chk({tag, " done_edge"}, 32'(k), 32'(lat));
    chk({tag, " busy_run"}, 32'(bad_busy), 32'd0);
    chk({tag, " held"}, 32'(bad_hold), 32'd0);
    chk({tag, " busy_at_done"}, 32'(Busy), 32'd0);
    chk({tag, " product"}, prod(), exp);
  endtask

  int inj;
  int dcount;
  logic [31:0] held;

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst product", prod(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle busy", 32'(Busy), 32'd0);

    // basic 3 * 5
    start_op(16'd3, 16'd5);
    chk("basic busy_e0", 32'(Busy), 32'd1);
    wait_done("basic", exp_lat(16'd5), 32'h0000000F, 32'd0);
    @(posedge clk);
    #1;
    chk("basic done_pulse", 32'(Done), 32'd0);
    chk("basic hold_idle", prod(), 32'h0000000F);

    // largest operands
    start_op(16'hFFFF, 16'hFFFF);
    wait_done("max", exp_lat(16'hFFFF), 32'hFFFE0001, 32'h0000000F);

    // Start during RUN must be ignored
    start_op(16'd2, 16'd7);
    inj = (exp_lat(16'd7) > 5) ? 5 : 1;
    repeat (inj - 1) @(posedge clk);
    @(negedge clk);
    Start = 1'b1;
    A     = 16'd9;
    B     = 16'd9;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_done("ignore", exp_lat(16'd7) - inj, 32'h0000000E, 32'hFFFE0001);
    dcount = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (Done) dcount++;
    end
    chk("ignore no_second_done", 32'(dcount), 32'd0);
    chk("ignore product_kept", prod(), 32'h0000000E);

    // back-to-back: Start held during the DONE cycle
    start_op(16'h00FF, 16'h0101);
    wait_done("b2b first", exp_lat(16'h0101), 32'h0000FFFF, 32'h0000000E);
    @(negedge clk);
    Start = 1'b1;
    A     = 16'h1234;
    B     = 16'h0010;
    @(posedge clk);
    #1;
    Start = 1'b0;
    chk("b2b busy_e0", 32'(Busy), 32'd1);
    chk("b2b done_e0", 32'(Done), 32'd0);
    wait_done("b2b second", exp_lat(16'h0010), 32'h00012340, 32'h0000FFFF);

    // asynchronous reset in the middle of a run
    start_op(16'hABCD, 16'h0101);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(Busy), 32'd0);
    chk("abort done", 32'(Done), 32'd0);
    chk("abort product", prod(), 32'd0);
    dcount = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (Done || Busy) dcount++;
    end
    chk("abort quiet", 32'(dcount), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(16'd4, 16'd4);
    wait_done("after_abort", exp_lat(16'd4), 32'h00000010, 32'd0);

    // operand-dependent latency cases
    start_op(16'h0100, 16'h0003);
    wait_done("early b3", exp_lat(16'h0003), 32'h00000300, 32'h00000010);
    start_op(16'h0005, 16'h0000);
    wait_done("early b0", exp_lat(16'h0000), 32'h00000000, 32'h00000300);
    held = prod();
    @(posedge clk);
    #1;
    chk("final idle done", 32'(Done), 32'd0);
    chk("final hold", prod(), held);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
